// File: rtl/alu_ctrl_issue_if.sv
// Valid/ready bundle between decode, the ALU-operation issue stage and execute.
// master = surrounding pipeline, slave = alu_ctrl_issue.
interface alu_ctrl_issue_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] ALUOp;
  logic [5:0] funct;
  logic [4:0] shamt_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ALUOperation;
  logic [4:0] shamt;
  logic       illegal;

  modport master (
    output in_valid, ALUOp, funct, shamt_in, out_ready,
    input  in_ready, out_valid, ALUOperation, shamt, illegal
  );

  modport slave (
    input  in_valid, ALUOp, funct, shamt_in, out_ready,
    output in_ready, out_valid, ALUOperation, shamt, illegal
  );
endinterface

// File: rtl/alu_ctrl_issue.sv
// Encodes ALUOp/funct/shamt into the ALU operation code through a registered stage
// with a one-entry skid buffer. Define ALU_ILL_COUNT_EN to add the ill_count counter.
module alu_ctrl_issue #(
  parameter logic [3:0] ILL_CODE = 4'b1111
`ifdef ALU_ILL_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  alu_ctrl_issue_if.slave  bus
`ifdef ALU_ILL_COUNT_EN
  , output logic [CNT_W-1:0] ill_count
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [4:0] sh;
    logic       ill;
  } payload_t;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1110;

  localparam payload_t RESET_PAYLOAD = '{op: ILL_CODE, sh: 5'd0, ill: 1'b0};

  function automatic payload_t legal_op(input logic [3:0] op);
    return '{op: op, sh: 5'd0, ill: 1'b0};
  endfunction

  state_t   state, state_nxt;
  payload_t main_q, skid_q, enc;
  logic     accept, pop;
  logic     load_main_new, load_main_skid, load_skid;

  always_comb begin
    enc = '{op: ILL_CODE, sh: 5'd0, ill: 1'b1};
    case (bus.ALUOp)
      3'b000: enc = legal_op(OP_ADD);
      3'b001: enc = legal_op(OP_SUB);
      3'b010: enc = legal_op(OP_AND);
      3'b011: enc = legal_op(OP_OR);
      3'b111: begin
        case (bus.funct)
          6'h20:   enc = legal_op(OP_ADD);
          6'h22:   enc = legal_op(OP_SUB);
          6'h24:   enc = legal_op(OP_AND);
          6'h25:   enc = legal_op(OP_OR);
          6'h27:   enc = legal_op(OP_NOR);
          6'h00:   enc = '{op: OP_SHIFT, sh: bus.shamt_in, ill: 1'b0};
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // in_ready looks only at registered state and flush, never at out_ready.
  assign bus.in_ready     = (state != FULL) & ~flush;
  assign bus.out_valid    = (state != EMPTY);
  assign bus.ALUOperation = main_q.op;
  assign bus.shamt        = main_q.sh;
  assign bus.illegal      = main_q.ill;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt      = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt     = ONE;
          load_main_new = 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            load_main_new = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      // NOTE: payload registers are reset too so ALUOperation reads ILL_CODE straight out of reset.
      main_q <= RESET_PAYLOAD;
      skid_q <= RESET_PAYLOAD;
    end else begin
      state <= state_nxt;
      if (load_main_new)       main_q <= enc;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= enc;
    end
  end

`ifdef ALU_ILL_COUNT_EN
  // Saturating count of illegal ops handed to execute; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      ill_count <= '0;
    end else if (pop && main_q.ill && !(&ill_count)) begin
      ill_count <= ill_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- Encoder/issuer side of the ALU operation interface.
- Takes the main-control ALUOp class plus the instruction funct and shamt fields, and encodes them into the 4-bit ALUOperation code and shamt the ALU consumes.
- Registered, valid/ready handshaked stage with a one-entry skid buffer, between decode and execute.
- Flags unsupported encodings and supports pipeline flush.

Parameters:
- ILL_CODE, 4'b1111, ALUOperation value emitted for illegal or unsupported ops; the ALU returns 0 for it.
- CNT_W, 8, width of the optional illegal-op counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline flush; discards all held entries
- in_valid  input  1  upstream has an op
- in_ready  output  1  stage can accept: ~skid_valid & ~flush
- ALUOp  input  3  main-control class: 000 ADD, 001 SUB, 010 AND, 011 OR, 111 R-type; others illegal
- funct  input  6  instr[5:0], used only when ALUOp=111
- shamt_in  input  5  instr[10:6]
- out_valid  output  1  ALUOperation/shamt valid to execute
- out_ready  input  1  execute accepts
- ALUOperation  output  4  AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, SHIFT 1110, else ILL_CODE
- shamt  output  5  shift amount; 0 unless ALUOperation=SHIFT
- illegal  output  1  current output op was unsupported
- ill_count  output  CNT_W  present only with ALU_ILL_COUNT_EN

Behaviour:
- Encoding (combinational, pre-register):
  - ALUOp 000/001/010/011 map to ADD/SUB/AND/OR.
  - ALUOp 111 decodes funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x00 SHIFT (sll).
  - Any other ALUOp/funct gives ILL_CODE with illegal=1.
  - shamt passes through only for SHIFT; otherwise 0.
- Storage: main output register (out_valid + payload) and one skid register (skid_valid + payload).
- Accept when in_valid & in_ready.
- Latency 1 cycle: an op accepted in cycle N appears on the outputs in cycle N+1.
- Pop when out_valid & out_ready.
- Transitions, evaluated each cycle (states EMPTY, ONE, FULL = main only, main+skid):
  - EMPTY + accept -> ONE; main <= new.
  - ONE + accept + pop -> ONE; main <= new.
  - ONE + accept, no pop -> FULL; skid <= new.
  - ONE + pop, no accept -> EMPTY.
  - FULL + pop -> ONE; main <= skid. No accept is possible in FULL because in_ready=0.
- Order is always preserved; no op is dropped or duplicated except on flush/reset.
- Output payload is stable while out_valid=1 and out_ready=0.
- in_ready depends only on registered state and flush; there is no combinational path from out_ready.
- flush=1: next cycle EMPTY. in_ready=0 during flush, so a concurrent input is not accepted. A concurrent pop is irrelevant.
- Reset values: out_valid=0, skid_valid=0, ALUOperation=ILL_CODE, shamt=0, illegal=0, ill_count=0.
  - in_ready=1 from the first cycle after reset.
- Reset beats flush and any handshake; reset mid-stream discards everything.
- Payload registers hold their values when empty; consumers qualify with out_valid.

Optional Feature:
- ALU_ILL_COUNT_EN defined:
  - ill_count port exists.
  - Increments by 1 on each pop with illegal=1, saturating at all-ones.
  - Cleared by reset only; flush does not clear it.
- ALU_ILL_COUNT_EN undefined: no port and no counter logic; all other behaviour identical.

Test Plan:
- Reset held 2 cycles -> out_valid=0, ALUOperation=1111, shamt=0, illegal=0, in_ready=1.
- ALUOp=111, funct=0x00, shamt_in=5, out_ready=1 -> next cycle out_valid=1, ALUOperation=1110, shamt=5.
- Then ALUOp=111, funct=0x27, shamt_in=3 -> ALUOperation=0010, shamt=0.
- Back-to-back ALUOp 000, 001, 010, 011 with out_ready=1 -> outputs 0011, 0100, 0000, 0001 in consecutive cycles, in_ready stays 1.
- out_ready=0 while sending ADD then SUB -> ADD held on outputs, in_ready=0 after the second accept, third input not taken.
  - Raise out_ready -> ADD, then SUB, then the third op, in order.
- ALUOp=111, funct=0x08 and ALUOp=101 -> ALUOperation=1111, illegal=1; with ALU_ILL_COUNT_EN, ill_count=2 after both pops.
  - 300 illegal pops -> ill_count=255.
- FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and concurrent ops never appear.
